mips_uart_rx: RTL and testbench

- Serial UART receiver that feeds the MIPS debug unit.
- Deserialises 8N1 frames from the host pin and presents each byte with a level-held ready flag.
- The flag stays high until the debug unit's rx-clear input acknowledges the byte.
- Contains its own oversampling baud-tick generator, input synchroniser, frame state machine and error flags.

---
 rtl/mips_uart_rx_if.sv | 29 ++
 rtl/mips_uart_rx.sv | 154 +++++++++++++++
 tb/tb_mips_uart_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_uart_rx_if.sv
// Debug-unit side of the MIPS UART receiver: serial line in, byte/flags out.
// With MIPS_UART_RX_PARITY_EN defined the bundle also carries o_parity_err.
interface mips_uart_rx_if #(parameter int DATA_BITS = 8);
   logic                 i_rx;
   logic                 i_rx_reset;
   logic [DATA_BITS-1:0] o_rx_data;
   logic                 o_rx_ready;
   logic                 o_frame_err;
   logic                 o_overrun;
`ifdef MIPS_UART_RX_PARITY_EN
   logic                 o_parity_err;
`endif

   modport slave (
      input  i_rx, i_rx_reset,
      output o_rx_data, o_rx_ready, o_frame_err, o_overrun
`ifdef MIPS_UART_RX_PARITY_EN
      , o_parity_err
`endif
   );

   modport master (
      output i_rx, i_rx_reset,
      input  o_rx_data, o_rx_ready, o_frame_err, o_overrun
`ifdef MIPS_UART_RX_PARITY_EN
      , o_parity_err
`endif
   );
endinterface

// File: rtl/mips_uart_rx.sv
// 8N1 UART receiver with oversampling tick, 2-flop synchroniser and sticky error flags.
// Define MIPS_UART_RX_PARITY_EN for 8E1 frames and the o_parity_err output.
module mips_uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int CLK_DIV    = 163,
   parameter int OVERSAMPLE = 16
) (
   input logic           clk,
   input logic           reset,
   mips_uart_rx_if.slave bus
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] T_LAST = CW'(CLK_DIV - 1);
   localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA,
`ifdef MIPS_UART_RX_PARITY_EN
      PARITY,
`endif
      STOP} state_t;

   state_t               state, state_d;
   logic [1:0]           sync;
   logic [CW-1:0]        tcnt;
   logic [SW-1:0]        s_cnt;
   logic [NW-1:0]        n_cnt;
   logic [DATA_BITS-1:0] shreg, rx_data;
   logic                 rx_s, tick, armed;
   logic                 rdy, fe, ov;
   logic                 s_clr, s_inc, n_clr, n_inc, do_shift, stop_smp;
`ifdef MIPS_UART_RX_PARITY_EN
   logic                 pe, par_bad, par_smp;
`endif

   assign rx_s = sync[1];
   assign tick = (tcnt == T_LAST);

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_d;

   always_comb begin
      state_d  = state;
      s_clr    = 1'b0;
      s_inc    = 1'b0;
      n_clr    = 1'b0;
      n_inc    = 1'b0;
      do_shift = 1'b0;
      stop_smp = 1'b0;
`ifdef MIPS_UART_RX_PARITY_EN
      par_smp  = 1'b0;
`endif
      case (state)
         // armed blocks a held-low line from being taken as a fresh start bit
         IDLE: if (!rx_s && armed) begin state_d = START; s_clr = 1'b1; end
         START: if (tick) begin
            if (s_cnt == S_HALF) begin
               if (rx_s) state_d = IDLE;
               else begin state_d = DATA; s_clr = 1'b1; n_clr = 1'b1; end
            end else s_inc = 1'b1;
         end
         DATA: if (tick) begin
            if (s_cnt == S_LAST) begin
               do_shift = 1'b1;
               s_clr    = 1'b1;
`ifdef MIPS_UART_RX_PARITY_EN
               if (n_cnt == N_LAST) state_d = PARITY;
`else
               if (n_cnt == N_LAST) state_d = STOP;
`endif
               else n_inc = 1'b1;
            end else s_inc = 1'b1;
         end
`ifdef MIPS_UART_RX_PARITY_EN
         PARITY: if (tick) begin
            if (s_cnt == S_LAST) begin par_smp = 1'b1; s_clr = 1'b1; state_d = STOP; end
            else s_inc = 1'b1;
         end
`endif
         STOP: if (tick) begin
            if (s_cnt == S_LAST) begin stop_smp = 1'b1; state_d = IDLE; end
            else s_inc = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync    <= 2'b11;
         tcnt    <= '0;
         s_cnt   <= '0;
         n_cnt   <= '0;
         shreg   <= '0;
         armed   <= 1'b1;
         rx_data <= '0;
         rdy     <= 1'b0;
         fe      <= 1'b0;
         ov      <= 1'b0;
`ifdef MIPS_UART_RX_PARITY_EN
         pe      <= 1'b0;
         par_bad <= 1'b0;
`endif
      end else begin
         sync <= {sync[0], bus.i_rx};
         tcnt <= tick ? '0 : tcnt + 1'b1;
         if (s_clr)      s_cnt <= '0;
         else if (s_inc) s_cnt <= s_cnt + 1'b1;
         if (n_clr)      n_cnt <= '0;
         else if (n_inc) n_cnt <= n_cnt + 1'b1;
         if (do_shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
`ifdef MIPS_UART_RX_PARITY_EN
         if (par_smp) par_bad <= (^shreg) ^ rx_s;
`endif
         if (state == IDLE && tick && rx_s) armed <= 1'b1;
         if (stop_smp) armed <= rx_s;

         // clear first so that a same-cycle completion below takes priority
         if (bus.i_rx_reset) begin
            rdy <= 1'b0;
            if (!rdy) begin
               fe <= 1'b0;
               ov <= 1'b0;
`ifdef MIPS_UART_RX_PARITY_EN
               pe <= 1'b0;
`endif
            end
         end
         if (stop_smp) begin
            if (!rx_s) fe <= 1'b1;
`ifdef MIPS_UART_RX_PARITY_EN
            else if (par_bad) pe <= 1'b1;
`endif
            else begin
               rx_data <= shreg;
               rdy     <= 1'b1;
               if (rdy && !bus.i_rx_reset) ov <= 1'b1;
            end
         end
      end
   end

   assign bus.o_rx_data   = rx_data;
   assign bus.o_rx_ready  = rdy;
   assign bus.o_frame_err = fe;
   assign bus.o_overrun   = ov;
`ifdef MIPS_UART_RX_PARITY_EN
   assign bus.o_parity_err = pe;
`endif
endmodule

// File: tb/tb_mips_uart_rx.sv
// Self-checking bench for mips_uart_rx: frames are driven bit-by-bit at the matching
// baud and outputs are compared against a frame-level model of data, ready and flags.
module tb_mips_uart_rx;
   localparam int CLK_DIV = 4;
   localparam int OS      = 16;
   localparam int BITCLK  = CLK_DIV * OS;
`ifdef MIPS_UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   mips_uart_rx_if #(.DATA_BITS(8)) bus ();
   mips_uart_rx #(.DATA_BITS(8), .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS)) u (
      .clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // model state
   logic [7:0] m_data;
   logic       m_rdy, m_fe, m_ov, m_pe;

   logic pe_obs;
`ifdef MIPS_UART_RX_PARITY_EN
   assign pe_obs = bus.o_parity_err;
`else
   assign pe_obs = 1'b0;
`endif
   logic [11:0] obs;
   assign obs = {bus.o_rx_data, bus.o_rx_ready, bus.o_frame_err, bus.o_overrun, pe_obs};

   function automatic logic [11:0] exp_vec();
      return {m_data, m_rdy, m_fe, m_ov, m_pe};
   endfunction

   task automatic mdl_reset();
      m_data = '0; m_rdy = 0; m_fe = 0; m_ov = 0; m_pe = 0;
   endtask

   task automatic mdl_frame(input logic [7:0] b, input bit par, input bit stp);
      if (!stp) m_fe = 1;
      else if (PAR && ((^b) ^ par)) m_pe = 1;
      else begin
         if (m_rdy) m_ov = 1;
         m_data = b;
         m_rdy  = 1;
      end
   endtask

   task automatic bit_out(input logic v);
      bus.i_rx = v;
      repeat (BITCLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par, input bit stp);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      if (PAR) bit_out(par);
      bit_out(stp);
      bit_out(1'b1);
      mdl_frame(b, par, stp);
   endtask

   task automatic ack();
      @(negedge clk) bus.i_rx_reset = 1'b1;
      @(negedge clk) bus.i_rx_reset = 1'b0;
      if (m_rdy) m_rdy = 0;
      else begin m_fe = 0; m_ov = 0; m_pe = 0; end
   endtask

   task automatic test_reset();
      mdl_reset();
      repeat (3) @(negedge clk);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_held got=%h want=%h", obs, exp_vec()); end
      reset = 1'b1;
      repeat (20) @(negedge clk);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_release got=%h want=%h", obs, exp_vec()); end
   endtask

   task automatic test_basic();
      send_frame(8'h72, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL basic_rx got=%h want=%h", obs, exp_vec()); end
      ack();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL basic_ack got=%h want=%h", obs, exp_vec()); end
   endtask

   task automatic test_overrun();
      send_frame(8'h73, ^8'h73, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL ovr_first got=%h want=%h", obs, exp_vec()); end
      send_frame(8'h6E, ^8'h6E, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL ovr_second got=%h want=%h", obs, exp_vec()); end
      ack();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL ovr_ack1 got=%h want=%h", obs, exp_vec()); end
      ack();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL ovr_ack2 got=%h want=%h", obs, exp_vec()); end
   endtask

   task automatic test_frame_err();
      send_frame(8'h55, ^8'h55, 1'b0);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL frame_err got=%h want=%h", obs, exp_vec()); end
      ack();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL frame_err_clr got=%h want=%h", obs, exp_vec()); end
   endtask

   task automatic test_break();
      bus.i_rx = 1'b0;
      repeat (BITCLK * 14) @(negedge clk);
      m_fe = 1;
      bus.i_rx = 1'b1;
      repeat (BITCLK) @(negedge clk);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL break_flag got=%h want=%h", obs, exp_vec()); end
      ack();
      send_frame(8'h81, ^8'h81, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL break_after got=%h want=%h", obs, exp_vec()); end
      ack();
   endtask

   task automatic test_glitch();
      bus.i_rx = 1'b0;
      repeat (3 * CLK_DIV) @(negedge clk);
      bus.i_rx = 1'b1;
      repeat (BITCLK * 2) @(negedge clk);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_idle got=%h want=%h", obs, exp_vec()); end
      send_frame(8'hA5, ^8'hA5, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_next got=%h want=%h", obs, exp_vec()); end
   endtask

   task automatic test_reset_midframe();
      bit_out(1'b0);
      for (int i = 0; i < 3; i++) bit_out(1'b1);
      repeat (BITCLK / 2) @(negedge clk);
      reset = 1'b0;
      mdl_reset();
      repeat (3) @(negedge clk);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL midrst_held got=%h want=%h", obs, exp_vec()); end
      reset = 1'b1;
      repeat (BITCLK * 7) @(negedge clk);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL midrst_tail got=%h want=%h", obs, exp_vec()); end
      send_frame(8'h3C, ^8'h3C, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL midrst_next got=%h want=%h", obs, exp_vec()); end
      ack();
   endtask

   task automatic test_random();
      logic [7:0] b;
      for (int k = 0; k < 8; k++) begin
         b = 8'($urandom);
         send_frame(b, ^b, 1'b1);
         n_chk++;
         if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand_%0d got=%h want=%h", k, obs, exp_vec()); end
         if ($urandom_range(1, 0) == 1) ack();
      end
      ack();
      ack();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand_final got=%h want=%h", obs, exp_vec()); end
   endtask

`ifdef MIPS_UART_RX_PARITY_EN
   task automatic test_parity();
      send_frame(8'h72, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL par_good got=%h want=%h", obs, exp_vec()); end
      ack();
      send_frame(8'h72, 1'b1, 1'b1);
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL par_bad got=%h want=%h", obs, exp_vec()); end
      ack();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL par_clr got=%h want=%h", obs, exp_vec()); end
   endtask
`endif

   initial begin
      bus.i_rx       = 1'b1;
      bus.i_rx_reset = 1'b0;
      test_reset();
      test_basic();
      test_overrun();
      test_frame_err();
      test_break();
      test_glitch();
      ack();
      test_reset_midframe();
      test_random();
`ifdef MIPS_UART_RX_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
